// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RISC-V M-extension multiply/divide unit.
//   - MD_* : funct3 operation codes
//   - state_e : controller states
//   - is_div() : true for the four divide/remainder operations
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  function automatic logic is_div(input logic [2:0] mode);
    return mode[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final result formation for muldiv_seq (purely combinational).
// Ports:
//   mode_i  : operation (funct3)
//   mag_i   : magnitude datapath contents; {product} for multiplies,
//             {remainder, quotient} for divides
//   neg_q_i : negate the product / quotient
//   neg_r_i : negate the remainder (follows the dividend sign)
//   res_o   : XLEN-bit architectural result
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        mode_i,
  input  logic [2*XLEN-1:0] mag_i,
  input  logic              neg_q_i,
  input  logic              neg_r_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    prod = neg_q_i ? -mag_i : mag_i;
    quo  = neg_q_i ? -mag_i[XLEN-1:0] : mag_i[XLEN-1:0];
    rem  = neg_r_i ? -mag_i[2*XLEN-1:XLEN] : mag_i[2*XLEN-1:XLEN];
    unique case (mode_i)
      MD_MUL:                       res_o = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_o = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_o = quo;
      default:                      res_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider share one 2*XLEN register:
// for multiplies it holds {partial product high, multiplier / product low},
// for divides {partial remainder, dividend / quotient}.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only while busy is low
//   mode       : funct3 operation select
//   a, b       : rs1 / rs2 operands
//   busy       : operation in flight (stall the pipeline)
//   done       : one-cycle pulse, result valid
//   result     : registered result, held until the next done
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// hardware multiplier (2-cycle latency); divides are unchanged.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  state_e              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at accept time.
  logic                a_sgn, b_sgn;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                b_zero, ovf;

  always_comb begin
    unique case (mode)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MD_MULHSU: begin
        a_sgn = 1'b1;
        b_sgn = 1'b0;
      end
      default: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
    endcase
    a_neg  = a_sgn & a[XLEN-1];
    b_neg  = b_sgn & b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    ovf    = ((mode == MD_DIV) || (mode == MD_REM)) &&
             (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod_full;
  assign a_ext     = {a_sgn & a[XLEN-1], a};
  assign b_ext     = {b_sgn & b[XLEN-1], b};
  assign prod_full = a_ext * b_ext;
`endif

  // One iteration of each algorithm on the shared register.
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_next  = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  logic [XLEN-1:0] fix_res;

  muldiv_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .mode_i  (mode_q),
    .mag_i   (acc_q),
    .neg_q_i (neg_q_q),
    .neg_r_i (neg_r_q),
    .res_o   (fix_res)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          cnt_d   = CNT_W'(XLEN);
          state_d = ST_CALC;
          if (is_div(mode)) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end
          if (is_div(mode) && b_zero) begin
            // Quotient all ones unsigned-style; remainder is the dividend.
            acc_d   = {a_mag, {XLEN{1'b1}}};
            neg_q_d = 1'b0;
            state_d = ST_FIX;
          end else if (ovf) begin
            acc_d   = {{XLEN{1'b0}}, a};
            neg_q_d = 1'b0;
            state_d = ST_FIX;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div(mode)) begin
            acc_d   = prod_full[2*XLEN-1:0];
            neg_q_d = 1'b0;
            state_d = ST_FIX;
          end
`endif
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = is_div(mode_q) ? div_next : mul_next;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
